// File: rtl/dk_audio_pkg.sv
// Shared types, constants and helpers for the DK audio mixer and its optional DC blocker.
package dk_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int GAIN_UNITY = 256;
    localparam int GAIN_W_DEF = 9;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [GAIN_W_DEF-1:0] gain_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT
    } mix_state_t;

    // Clamp an unsigned value to the 16-bit sample range.
    function automatic sample_t sat_u16(input logic [31:0] v);
        if (v > 32'd65535) begin
            return '1;
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/dk_dc_blocker.sv
// One-pole DC-blocking high-pass stage; only instantiated when AUDIO_MIXER_DC_BLOCK_EN is defined.
// Output is re-centred on 32768 and clamped to the unsigned 16-bit range.
module dk_dc_blocker
    import dk_audio_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    input  sample_t in,
    output logic    out_valid,
    output sample_t out
);

    localparam logic signed [18:0] MID = 19'sd32768;

    sample_t            r_x_prev;
    logic signed [17:0] r_y_prev;
    logic signed [17:0] w_y;
    logic signed [18:0] w_sum;
    sample_t            w_clamped;

    assign w_y   = $signed({2'b00, in}) - $signed({2'b00, r_x_prev})
                 + r_y_prev - (r_y_prev >>> DC_SHIFT);
    assign w_sum = MID + {w_y[17], w_y};

    always_comb begin
        w_clamped = w_sum[15:0];
        if (w_sum < 0) begin
            w_clamped = '0;
        end else if (w_sum > 19'sd65535) begin
            w_clamped = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_prev  <= '0;
            r_y_prev  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r_x_prev <= in;
                r_y_prev <= w_y;
                out      <= w_clamped;
            end
        end
    end

endmodule

// File: rtl/dk_audio_mixer.sv
// Time-multiplexed gain mixer: one shared MAC walks NUM_CH snapshotted channels per strobe.
// Optional DC-blocking output stage enabled by defining AUDIO_MIXER_DC_BLOCK_EN.
module dk_audio_mixer
    import dk_audio_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int GAIN_W   = 9,
    parameter int DC_SHIFT = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                audio_clk_en,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]     inputs,
    input  logic [NUM_CH-1:0][GAIN_W-1:0]       gains,
    output logic [SAMPLE_W-1:0]                 out,
    output logic                                out_valid,
    output logic                                busy,
    output logic                                overrun
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int ACC_W = SAMPLE_W + GAIN_W + $clog2(NUM_CH);
    localparam int RES_W = ACC_W - 8;

    if (NUM_CH < 2 || NUM_CH > 8 || DC_SHIFT < 1 || DC_SHIFT > 17) begin : g_bad_cfg
        $error("dk_audio_mixer: NUM_CH must be 2..8 and DC_SHIFT 1..17");
    end

    mix_state_t                          r_state;
    logic [IDX_W-1:0]                    r_idx;
    logic [ACC_W-1:0]                    r_acc;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]     r_snap_in;
    logic [NUM_CH-1:0][GAIN_W-1:0]       r_snap_gain;
    sample_t                             r_mix;
    logic                                r_mix_valid;
    logic                                r_busy;
    logic                                r_overrun;

    logic [SAMPLE_W-1:0]                 w_ch_in   [NUM_CH];
    logic [GAIN_W-1:0]                   w_ch_gain [NUM_CH];
    logic [ACC_W-1:0]                    w_term;
    logic [RES_W-1:0]                    w_res;
    logic                                w_accept;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign w_ch_in[gi]   = r_snap_in[gi];
        assign w_ch_gain[gi] = r_snap_gain[gi];
    end

    assign w_accept = (r_state == IDLE) && audio_clk_en;
    assign w_term   = ACC_W'(w_ch_in[r_idx]) * ACC_W'(w_ch_gain[r_idx]);
    // Q1.8 gain: drop the 8 fractional bits (floor) before saturating.
    assign w_res    = r_acc[ACC_W-1:8];

    // Snapshot isolates the in-flight mix from later input/gain changes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap_in   <= inputs;
            r_snap_gain <= gains;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (audio_clk_en) begin
                        r_state <= ACC;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ACC: begin
                    if (audio_clk_en) begin
                        r_overrun <= 1'b1;
                    end
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_CH - 1)) begin
                        r_state <= SAT;
                    end
                end
                SAT: begin
                    if (audio_clk_en) begin
                        r_overrun <= 1'b1;
                    end
                    r_mix       <= sat_u16(32'(w_res));
                    r_mix_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign overrun = r_overrun;

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    sample_t w_dc_out;
    logic    w_dc_valid;

    dk_dc_blocker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_mix_valid),
        .in        (r_mix),
        .out_valid (w_dc_valid),
        .out       (w_dc_out)
    );

    assign out       = w_dc_out;
    assign out_valid = w_dc_valid;
`else
    assign out       = r_mix;
    assign out_valid = r_mix_valid;
`endif

endmodule

// File: tb/tb_dk_audio_mixer.sv
// Scoreboard bench for dk_audio_mixer: directed scenarios plus randomized mixes vs. an arithmetic model.
module tb_dk_audio_mixer;
    import dk_audio_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int GAIN_W   = 9;
    localparam int DC_SHIFT = 10;
    localparam int MAXC     = 4096;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam int LAT = NUM_CH + 3;
`else
    localparam int LAT = NUM_CH + 2;
`endif

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             audio_clk_en;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  in_bus;
    logic [NUM_CH-1:0][GAIN_W-1:0]    gain_bus;
    logic [SAMPLE_W-1:0]              out;
    logic                             out_valid;
    logic                             busy;
    logic                             overrun;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   next_free = 0;
    bit   mon_en = 1'b0;
    bit   exp_busy [MAXC];
    bit   exp_ovr  [MAXC];
    bit   chk_zero [MAXC];
    exp_t q [$];
    int   cur_in [NUM_CH];
    int   cur_g  [NUM_CH];
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    int   xp = 0;
    int   yp = 0;
`endif

    dk_audio_mixer #(
        .NUM_CH   (NUM_CH),
        .GAIN_W   (GAIN_W),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .inputs       (in_bus),
        .gains        (gain_bus),
        .out          (out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc >= MAXC - 2) begin
            $display("FAIL watchdog: cycle %0d reached, limit %0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
    end

    // Reference: weighted sum, floor divide by unity gain, clamp to 16 bits.
    function automatic int ref_mix();
        longint s = 0;
        for (int i = 0; i < NUM_CH; i++) s += longint'(cur_in[i]) * longint'(cur_g[i]);
        s = s / GAIN_UNITY;
        return (s > 65535) ? 65535 : int'(s);
    endfunction

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    function automatic int dc_model(input int x);
        int y;
        int o;
        y  = x - xp + yp - (yp >>> DC_SHIFT);
        y  = (y <<< 14) >>> 14;
        xp = x;
        yp = y;
        o  = 32768 + y;
        if (o < 0) o = 0;
        if (o > 65535) o = 65535;
        return o;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_bus();
        for (int i = 0; i < NUM_CH; i++) begin
            in_bus[i]   = 16'(cur_in[i]);
            gain_bus[i] = 9'(cur_g[i]);
        end
    endtask

    task automatic do_strobe();
        exp_t e;
        int   x;
        apply_bus();
        audio_clk_en = 1'b1;
        if (cyc >= next_free) begin
            x = ref_mix();
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            x = dc_model(x);
`endif
            e.cyc = cyc + LAT;
            e.val = x;
            q.push_back(e);
            for (int k = cyc + 1; k <= cyc + NUM_CH + 1; k++) exp_busy[k] = 1'b1;
            next_free = cyc + NUM_CH + 2;
        end else begin
            for (int k = cyc + 1; k < MAXC; k++) exp_ovr[k] = 1'b1;
        end
        tick();
        audio_clk_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int j = 0; j < n; j++) begin
            reset = 1'b1;
            for (int k = cyc + 1; k < MAXC; k++) begin
                exp_busy[k] = 1'b0;
                exp_ovr[k]  = 1'b0;
            end
            chk_zero[cyc + 1] = 1'b1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc > cyc) q.delete(i);
            end
            next_free = cyc + 1;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            xp = 0;
            yp = 0;
`endif
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic set_all(input int inval, input int gval);
        for (int i = 0; i < NUM_CH; i++) begin
            cur_in[i] = inval;
            cur_g[i]  = gval;
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid and tracks held output, busy and overrun.
    int hold_val = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (chk_zero[cyc]) hold_val = 0;
            n_cmp++;
            if (out_valid === 1'b1) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL pulse: unexpected out_valid at cycle %0d, next expected cycle %0d",
                             cyc, (q.size() > 0) ? q[0].cyc : -1);
                    if (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
                end else begin
                    e = q.pop_front();
                    hold_val = e.val;
                    $display("mix   cycle %0d out=%0d expected=%0d", cyc, out, e.val);
                end
            end else if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL pulse: out_valid=%b at cycle %0d, required 0", out_valid, cyc);
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_err++;
                $display("FAIL pulse: missing out_valid at cycle %0d, required at %0d", cyc, e.cyc);
            end
            n_cmp++;
            if (out !== 16'(hold_val)) begin
                n_err++;
                $display("FAIL out: cycle %0d out=%0d, required %0d", cyc, out, hold_val);
            end
            n_cmp++;
            if (busy !== exp_busy[cyc]) begin
                n_err++;
                $display("FAIL busy: cycle %0d busy=%b, required %b", cyc, busy, exp_busy[cyc]);
            end
            n_cmp++;
            if (overrun !== exp_ovr[cyc]) begin
                n_err++;
                $display("FAIL overrun: cycle %0d overrun=%b, required %b", cyc, overrun, exp_ovr[cyc]);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        audio_clk_en = 1'b0;
        set_all(0, 0);
        apply_bus();
        tick();
        do_reset(3);
        mon_en = 1'b1;
        wait_cycles(2);

        // Unity sum
        for (int i = 0; i < NUM_CH; i++) begin
            cur_in[i] = 1000 * (i + 1);
            cur_g[i]  = GAIN_UNITY;
        end
        do_strobe();
        wait_cycles(10);

        // Saturation, then exact full scale
        set_all(65535, 128);
        do_strobe();
        wait_cycles(10);
        set_all(65535, 64);
        do_strobe();
        wait_cycles(10);

        // Isolation and floor
        set_all(65535, 0);
        cur_in[0] = 27307;
        cur_g[0]  = 256;
        do_strobe();
        wait_cycles(10);
        cur_g[0]  = 128;
        do_strobe();
        wait_cycles(10);

        // Overrun: strobe at c0, again at c0+3, then a clean one at c0+8
        set_all(500, 300);
        do_strobe();
        wait_cycles(2);
        set_all(9, 9);
        do_strobe();
        wait_cycles(4);
        set_all(1234, 200);
        do_strobe();
        wait_cycles(10);
        do_reset(1);
        wait_cycles(2);

        // Snapshot: inputs change two cycles after the strobe
        set_all(4000, 256);
        do_strobe();
        tick();
        set_all(60000, 511);
        apply_bus();
        wait_cycles(10);

        // Reset abort mid-mix
        set_all(7000, 256);
        do_strobe();
        wait_cycles(2);
        do_reset(1);
        wait_cycles(8);

        // Randomized mixes with random gaps (short gaps provoke overruns)
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_in[i] = int'($urandom_range(0, 65535));
                case ($urandom_range(0, 3))
                    0:       cur_g[i] = 0;
                    1:       cur_g[i] = GAIN_UNITY;
                    default: cur_g[i] = int'($urandom_range(0, 511));
                endcase
            end
            do_strobe();
            wait_cycles(int'($urandom_range(0, 9)));
            if (n == 20) do_reset(1);
        end

        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        wait_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
